// File: rtl/ahb_usb_pkg.sv
// Shared types and constants for the multi-endpoint AHB-Lite USB slave.
package ahb_usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REG    = 3'd1,
        ST_STREAM = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_t;

    localparam logic [4:0] OFF_STATUS = 5'h00;
    localparam logic [4:0] OFF_ERRS   = 5'h04;
    localparam logic [4:0] OFF_OCC    = 5'h08;
    localparam logic [4:0] OFF_TXPKT  = 5'h0C;
    localparam logic [4:0] OFF_FLUSH  = 5'h10;
    localparam logic [4:0] OFF_DATA   = 5'h14;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    function automatic logic [2:0] size_bytes(input logic [2:0] hsize);
        case (hsize)
            3'd0:    size_bytes = 3'd1;
            3'd1:    size_bytes = 3'd2;
            3'd2:    size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_usb_ep_regs.sv
// Per-endpoint state: TX packet request, sticky error bits, flush pulse and d_mode.
module ahb_usb_ep_regs
    import ahb_usb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       txpkt_we,
    input  logic [1:0] txpkt_wdata,
    input  logic       flush_pulse,
    input  logic       errs_rd,
    input  logic       rx_error,
    input  logic       tx_error,
    input  logic       tx_transfer_active,
    output logic [1:0] tx_packet,
    output logic [1:0] sticky,
    output logic       clear,
    output logic       d_mode
);

    logic [1:0] txpkt_q, txpkt_d;
    logic [1:0] sticky_q, sticky_d;
    logic       clear_q, clear_d;
    logic       d_mode_q, d_mode_d;

    // Next-state for the endpoint registers; a rising tx_transfer_active retires the request.
    always_comb begin
        txpkt_d  = txpkt_q;
        if (txpkt_we) begin
            txpkt_d = txpkt_wdata;
        end else if (tx_transfer_active && !d_mode_q) begin
            txpkt_d = 2'b00;
        end else begin
            txpkt_d = txpkt_q;
        end
        // New errors win over a same-cycle clear-on-read.
        sticky_d = (errs_rd ? 2'b00 : sticky_q) | {tx_error, rx_error};
        clear_d  = flush_pulse;
        d_mode_d = tx_transfer_active;
    end

    // Endpoint register storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            txpkt_q  <= 2'b00;
            sticky_q <= 2'b00;
            clear_q  <= 1'b0;
            d_mode_q <= 1'b0;
        end else begin
            txpkt_q  <= txpkt_d;
            sticky_q <= sticky_d;
            clear_q  <= clear_d;
            d_mode_q <= d_mode_d;
        end
    end

    assign tx_packet = txpkt_q;
    assign sticky    = sticky_q;
    assign clear     = clear_q;
    assign d_mode    = d_mode_q;

endmodule

// File: rtl/ahb_lite_usb_mep_slave.sv
// AHB-Lite slave exposing NUM_EP USB endpoint channels: decode, transfer FSM,
// byte-serial FIFO streaming with wait states and two-cycle ERROR responses.
module ahb_lite_usb_mep_slave
    import ahb_usb_pkg::*;
#(
    parameter  int NUM_EP     = 4,
    parameter  int FIFO_DEPTH = 64,
    parameter  int ADDR_W     = 8,
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hsel,
    input  logic [ADDR_W-1:0]       haddr,
    input  logic [1:0]              htrans,
    input  logic [2:0]              hsize,
    input  logic                    hwrite,
    input  logic [31:0]             hwdata,
    output logic [31:0]             hrdata,
    output logic                    hready,
    output logic                    hresp,
    input  logic [NUM_EP*3-1:0]     rx_packet,
    input  logic [NUM_EP-1:0]       rx_data_ready,
    input  logic [NUM_EP-1:0]       rx_transfer_active,
    input  logic [NUM_EP-1:0]       rx_error,
    input  logic [NUM_EP-1:0]       tx_transfer_active,
    input  logic [NUM_EP-1:0]       tx_error,
    input  logic [NUM_EP*OCC_W-1:0] buffer_occupancy,
    input  logic [NUM_EP*8-1:0]     rx_data,
    output logic [NUM_EP-1:0]       get_rx_data,
    output logic [NUM_EP-1:0]       store_tx_data,
    output logic [NUM_EP-1:0]       clear,
    output logic [NUM_EP-1:0]       d_mode,
    output logic [7:0]              tx_data,
    output logic [NUM_EP*2-1:0]     tx_packet
);

    localparam int CH_W = ADDR_W - 5;
    localparam int EP_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [EP_W-1:0]   ch_q, ch_d;
    logic [4:0]        off_q, off_d;
    logic              write_q, write_d;
    logic              is_data_q, is_data_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [31:0]       hrdata_q, hrdata_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hready_q, hready_d;
    logic              hresp_q, hresp_d;

    logic [CH_W-1:0]   a_ch_s;
    logic [4:0]        a_off_s;
    logic [EP_W-1:0]   a_ep_s;
    logic              ch_ok_s, off_ok_s, misalign_s, is_data_s, wr_ro_s, occ_err_s;
    logic              illegal_s, accept_s;
    logic [2:0]        size_n_s;
    logic [OCC_W-1:0]  occ_sel_s, free_s;
    logic [31:0]       rd_val_s;
    logic [NUM_EP*2-1:0] sticky_s;
    logic [NUM_EP-1:0] errs_rd_s, txpkt_we_s, flush_s, get_s, store_s;
    logic [7:0]        tx_data_s;
    logic              unused_s;

    // Address-phase decode, legality checks and register read value.
    always_comb begin
        a_ch_s     = haddr[ADDR_W-1:5];
        a_off_s    = haddr[4:0];
        ch_ok_s    = ({1'b0, a_ch_s} < (CH_W + 1)'(NUM_EP));
        if (ch_ok_s) begin
            a_ep_s = a_ch_s[EP_W-1:0];
        end else begin
            a_ep_s = {EP_W{1'b0}};
        end
        size_n_s   = size_bytes(hsize);
        occ_sel_s  = buffer_occupancy[a_ep_s*OCC_W +: OCC_W];
        free_s     = OCC_W'(FIFO_DEPTH) - occ_sel_s;
        off_ok_s   = (a_off_s[1:0] == 2'b00) && (a_off_s[4:2] <= 3'd5);
        misalign_s = ((hsize == 3'd1) && haddr[0]) || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
        is_data_s  = (a_off_s == OFF_DATA);
        wr_ro_s    = hwrite && ((a_off_s == OFF_STATUS) || (a_off_s == OFF_ERRS) || (a_off_s == OFF_OCC));
        occ_err_s  = is_data_s && (hwrite ? (free_s < OCC_W'(size_n_s)) : (occ_sel_s < OCC_W'(size_n_s)));
        illegal_s  = !ch_ok_s || !off_ok_s || (hsize > 3'd2) || misalign_s || wr_ro_s || occ_err_s;
        accept_s   = hsel && htrans[1] && hready_q && ((state_q == ST_IDLE) || (state_q == ST_REG));
        case (a_off_s)
            OFF_STATUS: rd_val_s = {24'h000000, rx_packet[a_ep_s*3 +: 3], tx_error[a_ep_s], rx_error[a_ep_s],
                                    tx_transfer_active[a_ep_s], rx_transfer_active[a_ep_s], rx_data_ready[a_ep_s]};
            OFF_ERRS:   rd_val_s = {30'h00000000, sticky_s[a_ep_s*2 +: 2]};
            OFF_OCC:    rd_val_s = {{(32 - OCC_W){1'b0}}, occ_sel_s};
            OFF_TXPKT:  rd_val_s = {30'h00000000, tx_packet[a_ep_s*2 +: 2]};
            default:    rd_val_s = 32'h00000000;
        endcase
    end

    // Transfer FSM: next state, captured address phase, lane assembly and bus response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        off_d     = off_q;
        write_d   = write_q;
        is_data_d = is_data_q;
        nbytes_d  = nbytes_q;
        hrdata_d  = hrdata_q;
        wdata_d   = wdata_q;
        errs_rd_s = {NUM_EP{1'b0}};
        case (state_q)
            ST_IDLE, ST_REG: begin
                if (accept_s) begin
                    ch_d      = a_ep_s;
                    off_d     = a_off_s;
                    write_d   = hwrite;
                    is_data_d = is_data_s;
                    nbytes_d  = size_n_s;
                    cnt_d     = 2'd0;
                    if (illegal_s) begin
                        state_d = ST_ERR1;
                    end else if (is_data_s) begin
                        state_d  = ST_STREAM;
                        hrdata_d = 32'h00000000;
                    end else begin
                        state_d  = ST_REG;
                        hrdata_d = hwrite ? 32'h00000000 : rd_val_s;
                        errs_rd_s[a_ep_s] = !hwrite && (a_off_s == OFF_ERRS);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (write_q) begin
                    wdata_d = (cnt_q == 2'd0) ? hwdata : wdata_q;
                end else begin
                    hrdata_d[{cnt_q, 3'b000} +: 8] = rx_data[ch_q*8 +: 8];
                end
                if ({1'b0, cnt_q} == (nbytes_q - 3'd1)) begin
                    state_d = ST_REG;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        hready_d = !((state_d == ST_STREAM) || (state_d == ST_ERR1));
        hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    // FIFO strobes and data-phase register writes for the captured channel.
    always_comb begin
        get_s      = {NUM_EP{1'b0}};
        store_s    = {NUM_EP{1'b0}};
        txpkt_we_s = {NUM_EP{1'b0}};
        flush_s    = {NUM_EP{1'b0}};
        tx_data_s  = 8'h00;
        if (state_q == ST_STREAM) begin
            if (write_q) begin
                store_s[ch_q] = 1'b1;
                tx_data_s     = (cnt_q == 2'd0) ? hwdata[7:0] : wdata_q[{cnt_q, 3'b000} +: 8];
            end else begin
                get_s[ch_q] = 1'b1;
            end
        end else if ((state_q == ST_REG) && write_q && !is_data_q) begin
            txpkt_we_s[ch_q] = (off_q == OFF_TXPKT);
            flush_s[ch_q]    = (off_q == OFF_FLUSH) && hwdata[0];
        end else begin
            tx_data_s = 8'h00;
        end
    end

    // Bus-side state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            ch_q      <= {EP_W{1'b0}};
            off_q     <= 5'h00;
            write_q   <= 1'b0;
            is_data_q <= 1'b0;
            nbytes_q  <= 3'd0;
            hrdata_q  <= 32'h00000000;
            wdata_q   <= 32'h00000000;
            hready_q  <= 1'b1;
            hresp_q   <= HRESP_OKAY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            off_q     <= off_d;
            write_q   <= write_d;
            is_data_q <= is_data_d;
            nbytes_q  <= nbytes_d;
            hrdata_q  <= hrdata_d;
            wdata_q   <= wdata_d;
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
        end
    end

    for (genvar g = 0; g < NUM_EP; g++) begin : g_ep
        ahb_usb_ep_regs u_regs (
            .clk                (clk),
            .rst                (rst),
            .txpkt_we           (txpkt_we_s[g]),
            .txpkt_wdata        (hwdata[1:0]),
            .flush_pulse        (flush_s[g]),
            .errs_rd            (errs_rd_s[g]),
            .rx_error           (rx_error[g]),
            .tx_error           (tx_error[g]),
            .tx_transfer_active (tx_transfer_active[g]),
            .tx_packet          (tx_packet[g*2 +: 2]),
            .sticky             (sticky_s[g*2 +: 2]),
            .clear              (clear[g]),
            .d_mode             (d_mode[g])
        );
    end

    assign hrdata        = hrdata_q;
    assign hready        = hready_q;
    assign hresp         = hresp_q;
    assign get_rx_data   = get_s;
    assign store_tx_data = store_s;
    assign tx_data       = tx_data_s;
    assign unused_s      = htrans[0];

endmodule

// File: doc/ahb_lite_usb_mep_slave.md
# ahb_lite_usb_mep_slave

Multi-endpoint AHB-Lite slave bridging the host bus to `NUM_EP` independent USB RX/TX endpoint channels. Each channel gets its own register window, status and error tracking, and a FIFO data window. Data-window accesses move 1, 2 or 4 bytes through the endpoint FIFO, one byte per cycle, using wait states. Illegal accesses get a full two-cycle AHB ERROR response with no side effects.

## Interface
Parameters:
- `NUM_EP`, 4: endpoint channel count (1–8)
- `FIFO_DEPTH`, 64: endpoint FIFO depth in bytes; `OCC_W = $clog2(FIFO_DEPTH+1)`
- `ADDR_W`, 8: `haddr` width; must be ≥ `5 + $clog2(NUM_EP)`

Ports:
- `clk` in 1: clock
- `rst` in 1: reset; synchronous, active-high
- `hsel` in 1: slave select
- `haddr` in `ADDR_W`: byte address; channel = `haddr[ADDR_W-1:5]`, offset = `haddr[4:0]`
- `htrans` in 2: transfer type; `htrans[1]` high means NONSEQ or SEQ
- `hsize` in 3: transfer size (0 = byte, 1 = half, 2 = word)
- `hwrite` in 1: write
- `hwdata` in 32: write data
- `hrdata` out 32: read data
- `hready` out 1: transfer done / slave ready
- `hresp` out 1: 1 = ERROR
- `rx_packet` in `NUM_EP*3`: per-channel RX packet type
- `rx_data_ready`, `rx_transfer_active`, `rx_error` in `NUM_EP` each
- `tx_transfer_active`, `tx_error` in `NUM_EP` each
- `buffer_occupancy` in `NUM_EP*OCC_W`: FIFO byte count
- `rx_data` in `NUM_EP*8`: FIFO head byte, combinational
- `get_rx_data`, `store_tx_data`, `clear`, `d_mode` out `NUM_EP` each
- `tx_data` out 8: shared byte to FIFO
- `tx_packet` out `NUM_EP*2`: TX packet request

## Operation
- Address phase is accepted when `hsel & htrans[1] & hready`. `haddr`, `hsize` and `hwrite` are registered at that edge.
- Per-channel offsets:
  - 0x00 STATUS (RO): `{rx_packet[2:0], tx_error, rx_error, tx_transfer_active, rx_transfer_active, rx_data_ready}` in bits [7:0]
  - 0x04 ERRS (RO, clear-on-read): bit0 sticky RX error, bit1 sticky TX error
  - 0x08 OCC (RO): `buffer_occupancy`, zero-extended
  - 0x0C TXPKT (RW) [1:0]
  - 0x10 FLUSH (WO): writing bit0 = 1 pulses `clear` for 1 cycle
  - 0x14 DATA: a read pops N bytes; a write pushes N bytes
  - N = 1 << `hsize`; bytes are little-endian, lane k = byte k
- ERROR conditions (checked at address phase):
  - channel ≥ `NUM_EP`
  - offset not in the map above
  - `hsize` > 2
  - address not aligned to N
  - write to 0x00–0x08
  - DATA read with occupancy < N
  - DATA write with `FIFO_DEPTH` − occupancy < N
- FSM states: IDLE, REG, STREAM, ERR1, ERR2.
  - IDLE: accepted legal non-DATA → REG; legal DATA → STREAM; illegal → ERR1.
  - REG: completes the access. Accepts a pipelined address phase, with the same transitions as IDLE; otherwise → IDLE.
  - STREAM: byte counter 0..N−1. At N−1 → completion cycle, which behaves like REG.
  - ERR1 → ERR2 → IDLE. No address phase is accepted in either ERR state.
- TXPKT: a nonzero write holds `tx_packet[ch]` until `tx_transfer_active[ch]` rises, then the field clears to 0.
- Sticky errors: set on `rx_error`/`tx_error`. A read of ERRS clears them; if set and clear happen in the same cycle, set wins.
- `d_mode[ch]` is `tx_transfer_active[ch]`, registered.

## Timing
- Reset values: `hrdata` = 0, `hready` = 1, `hresp` = 0, all strobes = 0, `tx_packet` = 0, `d_mode` = 0, sticky bits = 0, state = IDLE.
- Reset asserted mid-transfer: next edge goes to IDLE. No further strobes are issued.
- REG: zero wait. `hready` = 1 in the data-phase cycle; `hrdata` is valid in that cycle.
- STREAM read:
  - `hready` = 0 for N cycles.
  - In cycle k, `get_rx_data[ch]` = 1 and `rx_data` is captured into lane k.
  - Cycle N+1: `hready` = 1 and `hrdata` is valid.
  - Unused lanes read 0.
- STREAM write:
  - `hwdata` is captured in the first data-phase cycle.
  - For N cycles, `store_tx_data[ch]` = 1 with `tx_data` = lane k; `hready` = 0.
  - Cycle N+1: `hready` = 1.
- ERROR:
  - ERR1: `hready` = 0, `hresp` = 1.
  - ERR2: `hready` = 1, `hresp` = 1.
- At most one channel strobes per cycle.

## Structure
- Package `ahb_usb_pkg` holds: the state enum, register offset constants, the `HRESP_OKAY`/`HRESP_ERROR` constants, and a `size_bytes()` function.
- Sub-module `ahb_usb_ep_regs` is instantiated `NUM_EP` times via `generate`. It holds TXPKT, the sticky errors, the `clear` pulse and `d_mode`.
- The top level holds the FSM, byte counter, lane assembly and decode.

## Test plan
- Reset, then word read of ch1 STATUS with `rx_data_ready[1]` = 1 and `rx_packet[5:3]` = 3'b101 → `hrdata` = 0x000000A1, zero wait.
- Write 0x2 to ch0 TXPKT, then raise `tx_transfer_active[0]` 3 cycles later → `tx_packet[1:0]` = 2 until the rise, then 0; `d_mode[0]` = 1 one cycle later.
- ch2 occupancy 6, word read of DATA with bytes 0x11, 0x22, 0x33, 0x44 → 4 `get_rx_data[2]` pulses, `hready` low for 4 cycles, `hrdata` = 0x44332211.
- ch0 occupancy 62 of 64, word write of DATA → ERR1/ERR2, and no `store_tx_data`. Then a halfword write 0xBEEF → bytes 0xEF then 0xBE stored.
- Writes to 0x04; channel `NUM_EP`; unaligned halfword at 0x15 → each gives ERROR (`hready` 0 then 1, `hresp` 1), with no side effects.
- `rx_error[3]` pulses while ERRS is read on the same cycle → the read returns the prior value and the bit remains set. The next read returns bit0 = 1 and then clears it.
